// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer: collects FIR samples into FRAME-sample frames in two banks
// and presents each completed frame in parallel over a valid/ready handshake.
module fir_frame_buffer #(
  parameter int DW    = 16,
  parameter int FRAME = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fir_valid,
  input  logic [DW-1:0]         fir_d,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [DW*FRAME-1:0]   frame_data,
  output logic [7:0]            frame_cnt,
  output logic                  overflow
);
  localparam int IW = $clog2(FRAME);
  localparam logic [IW-1:0] LAST = IW'(FRAME - 1);

  typedef enum logic {W_FILL = 1'b0, W_DROP = 1'b1} wstate_t;

  wstate_t                           state, state_nxt;
  logic [1:0][FRAME-1:0][DW-1:0]     bank;
  logic [1:0]                        full, full_eff;
  logic                              wr_bank, rd_bank;
  logic [IW-1:0]                     wr_idx;
  logic                              rel, wr_en, drop_start, frame_done, drop_done;

  assign frame_valid = full[rd_bank];
  assign rel         = frame_valid & frame_ready;
  // a bank released this cycle may be refilled starting this same cycle
  assign full_eff    = full & ~{rel & rd_bank, rel & ~rd_bank};
  assign frame_data  = frame_valid ? bank[rd_bank] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= W_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_FILL: if (fir_valid && wr_idx == '0 && full_eff[wr_bank]) state_nxt = W_DROP;
      W_DROP: if (fir_valid && wr_idx == LAST)                    state_nxt = W_FILL;
      default: state_nxt = W_FILL;
    endcase
  end

  always_comb begin
    drop_start = (state == W_FILL) & fir_valid & (wr_idx == '0) & full_eff[wr_bank];
    wr_en      = (state == W_FILL) & fir_valid & ~drop_start;
    frame_done = wr_en & (wr_idx == LAST);
    drop_done  = (state == W_DROP) & fir_valid & (wr_idx == LAST);
  end

  // bank storage needs no reset: frame_data is gated by frame_valid
  always_ff @(posedge clk) begin
    if (wr_en) bank[wr_bank][wr_idx] <= fir_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      frame_cnt <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      // FRAME is a power of two, so the index wraps on its own; a dropped
      // first sample advances it to 1 like any other sample
      if (fir_valid)  wr_idx  <= wr_idx + 1'b1;
      if (frame_done) wr_bank <= ~wr_bank;
      if (rel) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 8'd1;
      end
      for (int b = 0; b < 2; b++) begin
        if (frame_done && wr_bank == b[0])  full[b] <= 1'b1;
        else if (rel && rd_bank == b[0])    full[b] <= 1'b0;
      end
      if (drop_done) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_frame_buffer.sv
// Bench for fir_frame_buffer: frame-queue reference model, directed cases plus random traffic.
module tb_fir_frame_buffer;
  localparam int DW = 16, FRAME = 16, FW = DW * FRAME;

  logic          clk = 1'b0;
  logic          rst, fir_valid, frame_ready;
  logic [DW-1:0] fir_d;
  logic          frame_valid, overflow;
  logic [FW-1:0] frame_data;
  logic [7:0]    frame_cnt;

  int n_tests = 0, n_fail = 0;

  fir_frame_buffer #(.DW(DW), .FRAME(FRAME)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
    .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_cnt(frame_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: FIFO of complete frames (at most two held), partial frame, drop mode
  logic [FW-1:0] q[$];
  logic [DW-1:0] part[FRAME];
  int            m_cnt;
  bit            m_drop, m_ovf;
  logic [7:0]    m_fcnt;

  function automatic void m_reset();
    q.delete();
    m_cnt = 0; m_drop = 0; m_ovf = 0; m_fcnt = 8'd0;
  endfunction

  task automatic check_outputs();
    chk("frame_valid", FW'(frame_valid), FW'(q.size() > 0));
    chk("frame_data", frame_data, (q.size() > 0) ? q[0] : '0);
    chk("frame_cnt", FW'(frame_cnt), FW'(m_fcnt));
    chk("overflow", FW'(overflow), FW'(m_ovf));
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r);
    bit            rel;
    logic [FW-1:0] f;
    @(negedge clk);
    check_outputs();
    fir_valid = v; fir_d = d; frame_ready = r;
    rel = (q.size() > 0) && r;
    if (rel) begin
      void'(q.pop_front());
      m_fcnt = m_fcnt + 8'd1;
    end
    if (v) begin
      if (!m_drop && m_cnt == 0 && q.size() == 2) begin
        m_drop = 1; m_cnt = 1;
      end else if (m_drop) begin
        m_cnt++;
        if (m_cnt == FRAME) begin m_drop = 0; m_cnt = 0; m_ovf = 1; end
      end else begin
        part[m_cnt] = d;
        m_cnt++;
        if (m_cnt == FRAME) begin
          for (int k = 0; k < FRAME; k++) f[k*DW +: DW] = part[k];
          q.push_back(f);
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; fir_valid = 1'b0; frame_ready = 1'b0; fir_d = '0;
    m_reset();
    #2 check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fir_valid = 1'b0; frame_ready = 1'b0; fir_d = '0;
    m_reset();
    #12 check_outputs();
    rst = 1'b0;

    // basic frame, held then accepted
    for (int i = 0; i < FRAME; i++) cyc(1, DW'(i), 0);
    cyc(0, '0, 0);
    chk("basic_valid", FW'(frame_valid), FW'(1'b1));
    chk("basic_s0", FW'(frame_data[15:0]), FW'(16'h0000));
    chk("basic_s15", FW'(frame_data[255:240]), FW'(16'h000F));
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("basic_cnt", FW'(frame_cnt), FW'(8'd1));
    chk("basic_drop_valid", FW'(frame_valid), FW'(1'b0));

    // ping-pong with ready held high until the second frame
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) cyc(1, 16'h1000 + DW'(i), 1);
    cyc(0, '0, 0);
    chk("pp_s0", FW'(frame_data[15:0]), FW'(16'h1010));
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("pp_cnt", FW'(frame_cnt), FW'(8'd2));
    chk("pp_ovf", FW'(overflow), FW'(1'b0));

    // overflow: third frame dropped
    do_reset();
    for (int i = 0; i < 3 * FRAME; i++) cyc(1, DW'(i), 0);
    cyc(0, '0, 0);
    chk("ovf_flag", FW'(overflow), FW'(1'b1));
    chk("ovf_f1_s0", FW'(frame_data[15:0]), FW'(16'h0000));
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("ovf_f2_s0", FW'(frame_data[15:0]), FW'(16'h0010));
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("ovf_empty", FW'(frame_valid), FW'(1'b0));

    // release and reuse in the same cycle as the first sample of frame 3
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) cyc(1, DW'(i), 0);
    cyc(1, 16'h2000, 1);
    for (int i = 1; i < FRAME; i++) cyc(1, 16'h2000 + DW'(i), 0);
    cyc(0, '0, 0);
    chk("reuse_ovf", FW'(overflow), FW'(1'b0));
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    chk("reuse_f3_s0", FW'(frame_data[15:0]), FW'(16'h2000));
    chk("reuse_f3_s15", FW'(frame_data[255:240]), FW'(16'h200F));

    // gaps in fir_valid
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 16'h3000 + DW'(i), 0);
    for (int i = 0; i < 5; i++)  cyc(0, 16'hDEAD, 0);
    for (int i = 10; i < 16; i++) cyc(1, 16'h3000 + DW'(i), 0);
    cyc(0, '0, 0);
    chk("gap_s9", FW'(frame_data[159:144]), FW'(16'h3009));
    chk("gap_s10", FW'(frame_data[175:160]), FW'(16'h300A));

    // reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) cyc(1, 16'h5000 + DW'(i), 1);
    do_reset();
    for (int i = 0; i < FRAME; i++) cyc(1, 16'h4000 + DW'(i), 0);
    cyc(0, '0, 0);
    chk("rst_s0", FW'(frame_data[15:0]), FW'(16'h4000));
    chk("rst_cnt", FW'(frame_cnt), FW'(8'd0));

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0);
    end
    cyc(0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
